// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants and code clamp helper for the PWM DAC
package dac_pkg;

    localparam int DAC_CYCLES_PER_WINDOW = 1024;
    localparam int DAC_CODE_WIDTH        = 10;

    function automatic int unsigned dac_clamp(input int unsigned code, input int unsigned n);
        return (code > n) ? n : code;
    endfunction

endpackage

// File: rtl/pwm_dac_if.sv
// rtl/pwm_dac_if.sv - producer/DAC sample handshake; mute exists only with PWM_DAC_MUTE_EN
interface pwm_dac_if
    import dac_pkg::*;
#(
    parameter int CODE_WIDTH = DAC_CODE_WIDTH
);
    logic [CODE_WIDTH-1:0] code;
    logic                  next_sample;
`ifdef PWM_DAC_MUTE_EN
    logic                  mute;

    modport master (output code, output mute, input next_sample);
    modport slave  (input code, input mute, output next_sample);
`else
    modport master (output code, input next_sample);
    modport slave  (input code, output next_sample);
`endif
endinterface

// File: rtl/pwm_window_counter.sv
// rtl/pwm_window_counter.sv - free-running 0..N-1 window counter with registered request/load strobes
module pwm_window_counter
    import dac_pkg::*;
#(
    parameter int N = DAC_CYCLES_PER_WINDOW
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [$clog2(N)-1:0] cnt,
    output logic                 req,
    output logic                 load
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST     = CW'(N - 1);
    localparam logic [CW-1:0] PRE_LOAD = CW'(N - 2);
    localparam logic [CW-1:0] PRE_REQ  = CW'(N - 3);

    // Strobes are decoded one count early so they line up with cnt when registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            req  <= 1'b0;
            load <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
            req  <= (cnt == PRE_REQ);
            load <= (cnt == PRE_LOAD);
        end
    end

endmodule

// File: rtl/pwm_dac.sv
// rtl/pwm_dac.sv - PWM DAC top: window-latched duty and registered PWM; optional mute via PWM_DAC_MUTE_EN
module pwm_dac
    import dac_pkg::*;
#(
    parameter int CYCLES_PER_WINDOW = DAC_CYCLES_PER_WINDOW,
    parameter int CODE_WIDTH        = DAC_CODE_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    pwm_dac_if.slave   bus,
    output logic       pwm
);
    localparam int N  = CYCLES_PER_WINDOW;
    localparam int CW = $clog2(N);
    localparam int DW = $clog2(N + 1);

    logic [CW-1:0]         cnt;
    logic                  req;
    logic                  load;
    logic [DW-1:0]         duty;
    logic [DW-1:0]         duty_next;
    logic [CODE_WIDTH-1:0] code_in;

    pwm_window_counter #(.N(N)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .req  (req),
        .load (load)
    );

    assign bus.next_sample = req;
    assign code_in         = bus.code;

    always_comb begin
        duty_next = DW'(dac_clamp(32'(code_in), 32'(N)));
`ifdef PWM_DAC_MUTE_EN
        // Midscale is silence; applied only at the window boundary, so no glitch.
        if (bus.mute) begin
            duty_next = DW'(N / 2);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            if (load) begin
                duty <= duty_next;
            end
            pwm <= (DW'(cnt) < duty);
        end
    end

endmodule
